gpio_uart_tx: RTL

- Downstream consumer of the MIPS multi-cycle core's 8-bit GPIO output bus.
- Detects every change of the GPIO byte, queues the changes in a small FIFO and serialises them as 8N1 UART frames (optional parity) on one TX pin.
- Gives a board-level trace of the program's GPIO writes without a logic analyser.
- Sits beside the core top level, driven by the same clock and reset.

---
 rtl/gpio_uart_pkg.sv | 24 ++
 rtl/gpio_uart_tx_if.sv | 24 ++
 rtl/gpio_uart_tx_sync_fifo.sv | 61 ++++++
 rtl/gpio_uart_tx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/gpio_uart_pkg.sv
// Shared types and constants for the GPIO-change UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a. The optional parity state exists only when GPIO_UART_PARITY_EN is defined.
package gpio_uart_pkg;

   localparam int FRAME_BITS_8N1 = 10;
   localparam int FRAME_BITS_8E1 = 11;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef GPIO_UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_e;

   // Cycles per UART bit; integer truncation is intended.
   function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/gpio_uart_tx_if.sv
// Bus between the GPIO producer and the UART tracer: GPIO byte in, line and status out.
// Latency: n/a (wiring only).
// Backpressure: none; the producer is never stalled, overflow is reported instead.
interface gpio_uart_tx_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]       gpio_i;
   logic             tx_o;
   logic             busy_o;
   logic             overflow_o;
   logic [CNT_W-1:0] fifo_count_o;

   modport master (
      output gpio_i,
      input  tx_o, busy_o, overflow_o, fifo_count_o
   );

   modport slave (
      input  gpio_i,
      output tx_o, busy_o, overflow_o, fifo_count_o
   );
endinterface

// File: rtl/gpio_uart_tx_sync_fifo.sv
// Generic synchronous FIFO with head data visible combinationally.
// Latency: a pushed word is readable at the head one cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored; the caller watches full/empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);
   assign count  = count_q;
   assign rd_dat = mem_q[rd_ptr_q];

   // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   // Pointer and count registers; storage itself needs no reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_dat;
      end
   end

endmodule

// File: rtl/gpio_uart_tx.sv
// Traces every GPIO byte change as a UART frame (8N1, or 8E1 when GPIO_UART_PARITY_EN is defined).
// Latency: push on the edge that sees the change, start bit driven from the following edge.
// Backpressure: none upstream; changes arriving with a full FIFO are dropped and flag overflow_o.
module gpio_uart_tx
   import gpio_uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   gpio_uart_tx_if.slave       bus
);

   localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
   localparam int BW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam int CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    prev_q;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          overflow_q, overflow_d;

   logic          chg, push_ok, pop;
   logic [7:0]    head;
   logic          full, empty;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_next;
   logic          baud_end;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (chg),
      .wr_dat (bus.gpio_i),
      .pop    (pop),
      .rd_dat (head),
      .full   (full),
      .empty  (empty),
      .count  (fifo_count)
   );

   assign bus.tx_o         = tx_q;
   assign bus.busy_o       = busy_q;
   assign bus.overflow_o   = overflow_q;
   assign bus.fifo_count_o = fifo_count;

   // Change detect, frame sequencing and next values of every registered output.
   always_comb begin
      chg        = (bus.gpio_i != prev_q);
      push_ok    = chg && !full;
      overflow_d = overflow_q || (chg && full);
      baud_end   = (baud_q == BAUD_LAST);

      pop     = 1'b0;
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               baud_d  = '0;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef GPIO_UART_PARITY_EN
                  state_d = PARITY;
                  tx_d    = ^shift_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[bit_q + 3'd1];
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
`ifdef GPIO_UART_PARITY_EN
         PARITY: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = STOP;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
`endif
         STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = IDLE;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
         end
      endcase

      // busy tracks the state and occupancy that will hold after this edge.
      count_next = fifo_count + CW'(push_ok) - CW'(pop);
      busy_d     = (state_d != IDLE) || (count_next != '0);
   end

   // All control state and outputs; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= 3'd0;
         shift_q    <= 8'h00;
         prev_q     <= 8'h00;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         prev_q     <= bus.gpio_i;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
